// File: rtl/uart_pkg.sv
// Shared UART constants for the loopback path: data width, board clock and FIFO defaults.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int CLK_FREQ_HZ        = 27_000_000;
  localparam int DEFAULT_DEPTH      = 16;
  localparam int DEFAULT_GAP_CYCLES = 2_000_000;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM for the RX byte FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between uart_rx and uart_tx with a first-word fall-through output register.
// Optional TX pacing (idle gap after each transfer) is enabled by defining UART_FIFO_PACE_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx_done,
  input  logic [7:0]             i_rx_data,
  output logic                   o_rx_ack,
  output logic                   o_tx_valid,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_ready,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                   rx_ack_reg, rx_ack_next;
  logic                   overflow_reg, overflow_next;
  logic [PTR_W-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic                   out_full_reg, out_full_next;
  logic [UART_DATA_W-1:0] tx_data_reg, tx_data_next;
  logic [GAP_W-1:0]       pace_cnt_reg, pace_cnt_next;

  logic                   capture;
  logic                   full;
  logic                   push;
  logic                   tx_valid;
  logic                   pop;
  logic                   mem_nonempty;
  logic                   load;
  logic [UART_DATA_W-1:0] mem_rd_data;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (i_rx_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    capture  = i_rx_done && !rx_ack_reg;
    full     = (count_reg == FULL_CNT);
    push     = capture && !full;
    tx_valid = out_full_reg && (pace_cnt_reg == '0);
    pop      = tx_valid && i_tx_ready;
    // Memory occupancy is the total count minus the output register's byte.
    mem_nonempty = (count_reg != {{PTR_W{1'b0}}, out_full_reg});
    load     = mem_nonempty && (!out_full_reg || pop);
  end

  always_comb begin
    rx_ack_next   = rx_ack_reg;
    overflow_next = overflow_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    out_full_next = out_full_reg;
    tx_data_next  = tx_data_reg;
    pace_cnt_next = pace_cnt_reg;

    if (!i_rx_done) begin
      rx_ack_next = 1'b0;
    end else if (capture) begin
      rx_ack_next = 1'b1;
    end

    // A full buffer drops the byte but still acknowledges so uart_rx never stalls.
    if (capture && full) begin
      overflow_next = 1'b1;
    end

    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end

    if (load) begin
      rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
      tx_data_next  = mem_rd_data;
      out_full_next = 1'b1;
    end else if (pop) begin
      out_full_next = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase

`ifdef UART_FIFO_PACE_EN
    if (pop) begin
      pace_cnt_next = GAP_W'(GAP_CYCLES);
    end else if (pace_cnt_reg != '0) begin
      pace_cnt_next = pace_cnt_reg - GAP_W'(1);
    end
`else
    pace_cnt_next = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_ack_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      out_full_reg <= 1'b0;
      tx_data_reg  <= '0;
      pace_cnt_reg <= '0;
    end else begin
      rx_ack_reg   <= rx_ack_next;
      overflow_reg <= overflow_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      out_full_reg <= out_full_next;
      tx_data_reg  <= tx_data_next;
      pace_cnt_reg <= pace_cnt_next;
    end
  end

  assign o_rx_ack   = rx_ack_reg;
  assign o_tx_valid = tx_valid;
  assign o_tx_data  = tx_data_reg;
  assign o_count    = count_reg;
  assign o_empty    = (count_reg == '0);
  assign o_full     = full;
  assign o_overflow = overflow_reg;

endmodule
